cam_partitioned_cfg: RTL

Parametrised successor to the fixed 4-way partitioned CAM. It supports any power-of-two NUM_PARTS, an optional registered match output, and per-partition power-gating. Each partition runs its own re-initialisation sequencer whenever it is ungated, and ramReady_o is derived from the partition states. It sits wherever the core needs a gated associative lookup, such as the issue-queue wakeup and the LSQ disambiguation CAMs.

---
 rtl/cam_cfg_pkg.sv | 24 ++
 rtl/cam_cfg_partition.sv | 111 +++++++++++
 rtl/cam_partitioned_cfg.sv | 119 +++++++++++
 3 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the partitioned, power-gated CAM.
//   part_state_t   : per-partition lifecycle (OFF, INIT, READY)
//   RAM_RESET_*    : selects the contents written by the init sequencer
//   init_val()     : sequential init value for entry e of partition p
package cam_cfg_pkg;

  typedef enum logic [1:0] {
    OFF,
    INIT,
    READY
  } part_state_t;

  localparam int unsigned RAM_RESET_ZERO = 0;
  localparam int unsigned RAM_RESET_SEQ  = 1;

  // Caller truncates to the tag width.
  function automatic int unsigned init_val(input int unsigned seq_start,
                                           input int unsigned part_depth,
                                           input int unsigned p,
                                           input int unsigned e);
    return seq_start + p * part_depth + e;
  endfunction

endpackage

// File: rtl/cam_cfg_partition.sv
// One CAM partition: storage, lifecycle FSM with init sequencer, write
// arbitration, match logic and dropped-write detection.
//   clk, rst_n  : clock, asynchronous active-low reset
//   gate        : 1 = partition powered down
//   rd_gated    : per search port, 1 = force that port's match bits to 0
//   tag         : search tags
//   vect        : per search port, local match vector (bit e = entry e)
//   wr_sel      : per write port, enabled ungated write targeting this partition
//   wr_entry    : per write port, local entry index
//   wr_data     : per write port, data
//   drop        : registered, write targeted this partition while not READY
//   ready, off  : registered state flags
module cam_cfg_partition
  import cam_cfg_pkg::*;
#(
  parameter int unsigned PART_ID      = 0,
  parameter int unsigned PART_DEPTH   = 16,
  parameter int unsigned PART_AW      = 4,
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned NUM_RD_PORTS = 4,
  parameter int unsigned NUM_WR_PORTS = 4,
  parameter int unsigned RESET_VAL    = RAM_RESET_ZERO,
  parameter int unsigned SEQ_START    = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     gate,
  input  logic [NUM_RD_PORTS-1:0]                  rd_gated,
  input  logic [NUM_RD_PORTS-1:0][WIDTH-1:0]       tag,
  output logic [NUM_RD_PORTS-1:0][PART_DEPTH-1:0]  vect,
  input  logic [NUM_WR_PORTS-1:0]                  wr_sel,
  input  logic [NUM_WR_PORTS-1:0][PART_AW-1:0]     wr_entry,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]       wr_data,
  output logic [NUM_WR_PORTS-1:0]                  drop,
  output logic                                     ready,
  output logic                                     off
);

  localparam logic [PART_AW-1:0] LAST = PART_AW'(PART_DEPTH - 1);

  logic [WIDTH-1:0] mem [PART_DEPTH];
  part_state_t      state;
  logic [PART_AW-1:0] cnt;
  logic [WIDTH-1:0] init_word;

  always_comb begin
    init_word = '0;
    if (RESET_VAL == RAM_RESET_SEQ)
      init_word = WIDTH'(init_val(SEQ_START, PART_DEPTH, PART_ID, 32'(cnt)));
  end

  // Storage has no reset: INIT rewrites every entry before READY.
  // Later ports overwrite earlier ones, so the highest-numbered port wins.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= init_word;
    end else if (state == READY) begin
      for (int unsigned wp = 0; wp < NUM_WR_PORTS; wp++)
        if (wr_sel[wp]) mem[wr_entry[wp]] <= wr_data[wp];
    end
  end

  always_comb begin
    vect = '0;
    for (int unsigned rp = 0; rp < NUM_RD_PORTS; rp++)
      for (int unsigned e = 0; e < PART_DEPTH; e++)
        vect[rp][e] = (state == READY) && !rd_gated[rp] && (mem[e] == tag[rp]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
      off   <= 1'b0;
      drop  <= '0;
    end else begin
      drop <= wr_sel & {NUM_WR_PORTS{state != READY}};
      if (gate) begin
        state <= OFF;
        cnt   <= '0;
        ready <= 1'b0;
        off   <= 1'b1;
      end else begin
        case (state)
          OFF: begin
            state <= INIT;
            cnt   <= '0;
            off   <= 1'b0;
          end
          INIT: begin
            if (cnt == LAST) begin
              state <= READY;
              ready <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          READY: ;
          default: begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
            off   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cam_partitioned_cfg.sv
// Partitioned associative lookup with per-partition power gating.
//   clk, reset         : clock, asynchronous active-low reset
//   partitionGated_i   : 1 = partition powered down
//   readPortGated_i    : 1 = search port output forced to 0
//   writePortGated_i   : 1 = write port ignored
//   tag_i / vect_o     : search tags / match vectors (bit i = entry i)
//   addrWr_i, dataWr_i, wrEn_i : write ports (top address bits = partition)
//   wrDrop_o           : registered pulse, enabled ungated write was dropped
//   partReady_o        : partition READY flags
//   ramReady_o         : registered, every partition READY or OFF
module cam_partitioned_cfg
  import cam_cfg_pkg::*;
#(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned INDEX         = 6,
  parameter int unsigned WIDTH         = 7,
  parameter int unsigned NUM_RD_PORTS  = 4,
  parameter int unsigned NUM_WR_PORTS  = 4,
  parameter int unsigned NUM_PARTS     = 4,
  parameter int unsigned NUM_PARTS_LOG = 2,
  parameter int unsigned READ_LATENCY  = 0,
  parameter int unsigned RESET_VAL     = RAM_RESET_ZERO,
  parameter int unsigned SEQ_START     = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PARTS-1:0]                 partitionGated_i,
  input  logic [NUM_RD_PORTS-1:0]              readPortGated_i,
  input  logic [NUM_WR_PORTS-1:0]              writePortGated_i,
  input  logic [NUM_RD_PORTS-1:0][WIDTH-1:0]   tag_i,
  output logic [NUM_RD_PORTS-1:0][DEPTH-1:0]   vect_o,
  input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]   addrWr_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]   dataWr_i,
  input  logic [NUM_WR_PORTS-1:0]              wrEn_i,
  output logic [NUM_WR_PORTS-1:0]              wrDrop_o,
  output logic [NUM_PARTS-1:0]                 partReady_o,
  output logic                                 ramReady_o
);

  localparam int unsigned PART_DEPTH = DEPTH / NUM_PARTS;
  localparam int unsigned PART_AW    = (PART_DEPTH > 1) ? $clog2(PART_DEPTH) : 1;

  logic [NUM_PARTS-1:0][NUM_WR_PORTS-1:0]                 wr_sel;
  logic [NUM_WR_PORTS-1:0][PART_AW-1:0]                   wr_entry;
  logic [NUM_PARTS-1:0][NUM_RD_PORTS-1:0][PART_DEPTH-1:0] part_vect;
  logic [NUM_PARTS-1:0][NUM_WR_PORTS-1:0]                 part_drop;
  logic [NUM_PARTS-1:0]                                   part_ready;
  logic [NUM_PARTS-1:0]                                   part_off;
  logic [NUM_RD_PORTS-1:0][DEPTH-1:0]                     vect_c;
  logic [NUM_WR_PORTS-1:0]                                drop_c;

  // Shift and modulo keep the decode valid for NUM_PARTS == 1 (no select bits).
  always_comb begin
    wr_sel   = '0;
    wr_entry = '0;
    for (int unsigned wp = 0; wp < NUM_WR_PORTS; wp++) begin
      wr_entry[wp] = PART_AW'(32'(addrWr_i[wp]) % PART_DEPTH);
      for (int unsigned p = 0; p < NUM_PARTS; p++)
        if (wrEn_i[wp] && !writePortGated_i[wp] &&
            ((32'(addrWr_i[wp]) >> (INDEX - NUM_PARTS_LOG)) == p))
          wr_sel[p][wp] = 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
    cam_cfg_partition #(
      .PART_ID      (p),
      .PART_DEPTH   (PART_DEPTH),
      .PART_AW      (PART_AW),
      .WIDTH        (WIDTH),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .RESET_VAL    (RESET_VAL),
      .SEQ_START    (SEQ_START)
    ) u_part (
      .clk      (clk),
      .rst_n    (reset),
      .gate     (partitionGated_i[p]),
      .rd_gated (readPortGated_i),
      .tag      (tag_i),
      .vect     (part_vect[p]),
      .wr_sel   (wr_sel[p]),
      .wr_entry (wr_entry),
      .wr_data  (dataWr_i),
      .drop     (part_drop[p]),
      .ready    (part_ready[p]),
      .off      (part_off[p])
    );
  end

  // Each write port selects at most one partition, so OR-ing drops is exact.
  always_comb begin
    vect_c = '0;
    drop_c = '0;
    for (int unsigned p = 0; p < NUM_PARTS; p++) begin
      drop_c = drop_c | part_drop[p];
      for (int unsigned rp = 0; rp < NUM_RD_PORTS; rp++)
        vect_c[rp][p*PART_DEPTH +: PART_DEPTH] = part_vect[p][rp];
    end
  end

  assign wrDrop_o    = drop_c;
  assign partReady_o = part_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ramReady_o <= 1'b0;
    else        ramReady_o <= &(part_ready | part_off);
  end

  if (READ_LATENCY == 1) begin : g_vect_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) vect_o <= '0;
      else        vect_o <= vect_c;
    end
  end else begin : g_vect_comb
    assign vect_o = vect_c;
  end

endmodule
